// File: rtl/length_adjust_counter.sv
// Up/down length counter driven by two raw push-buttons.
// Each button is synchronised and edge-detected. A lone held button auto-repeats
// its step after a hold delay. The count saturates or wraps at its bounds, and
// the frame sync clears it to MIN_VAL.
module length_adjust_counter #(
  parameter int unsigned WIDTH         = 7,
  parameter int unsigned MIN_VAL       = 0,
  parameter int unsigned MAX_VAL       = 127,
  parameter int unsigned WRAP          = 0,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             sync,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             changed
);

  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
  localparam logic [TW-1:0]    HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    REP_LD  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  logic             r_up_s1, r_up_s2, r_up_prev;
  logic             r_dn_s1, r_dn_s2, r_dn_prev;
  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic             r_dir_up, w_dir_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt, w_step_val;
  logic             r_changed;

  logic w_up_rise, w_dn_rise, w_up_only, w_dn_only, w_lone;
  logic w_step, w_step_up;

  assign w_up_rise = r_up_s2 & ~r_up_prev;
  assign w_dn_rise = r_dn_s2 & ~r_dn_prev;
  assign w_up_only = r_up_s2 & ~r_dn_s2;
  assign w_dn_only = r_dn_s2 & ~r_up_s2;
  assign w_lone    = r_dir_up ? w_up_only : w_dn_only;

  // Two-flop synchronisers plus previous-value flops for edge detection
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_up_s1   <= 1'b0;
      r_up_s2   <= 1'b0;
      r_up_prev <= 1'b0;
      r_dn_s1   <= 1'b0;
      r_dn_s2   <= 1'b0;
      r_dn_prev <= 1'b0;
    end else begin
      r_up_s1   <= btn_up;
      r_up_s2   <= r_up_s1;
      r_up_prev <= r_up_s2;
      r_dn_s1   <= btn_down;
      r_dn_s2   <= r_dn_s1;
      r_dn_prev <= r_dn_s2;
    end
  end

  // Press / hold / repeat sequencing: decides when a step is issued and its direction
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dir_nxt   = r_dir_up;
    w_step      = 1'b0;
    w_step_up   = r_dir_up;
    case (r_state)
      ST_IDLE: begin
        if (w_up_rise && w_up_only) begin
          w_step      = 1'b1;
          w_step_up   = 1'b1;
          w_dir_nxt   = 1'b1;
          w_timer_nxt = HOLD_LD;
          if (REPEAT_EN != 0) w_state_nxt = ST_HOLD;
        end else if (w_dn_rise && w_dn_only) begin
          w_step      = 1'b1;
          w_step_up   = 1'b0;
          w_dir_nxt   = 1'b0;
          w_timer_nxt = HOLD_LD;
          if (REPEAT_EN != 0) w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!w_lone) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer == '0) begin
          w_step      = 1'b1;
          w_timer_nxt = REP_LD;
          w_state_nxt = ST_REPEAT;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state, timer and latched direction
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_dir_up <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_dir_up <= w_dir_nxt;
    end
  end

  // Bounded step arithmetic, then sync clear taking priority over any step
  always_comb begin
    w_step_val = r_count;
    if (w_step_up) begin
      if (r_count < MAX_V) w_step_val = r_count + WIDTH'(1);
      else                 w_step_val = (WRAP != 0) ? MIN_V : MAX_V;
    end else begin
      if (r_count > MIN_V) w_step_val = r_count - WIDTH'(1);
      else                 w_step_val = (WRAP != 0) ? MAX_V : MIN_V;
    end
    w_count_nxt = r_count;
    if (sync)        w_count_nxt = MIN_V;
    else if (w_step) w_count_nxt = w_step_val;
  end

  // Count register and change pulse (high only when the value actually moved)
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count   <= MIN_V;
      r_changed <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_changed <= (w_count_nxt != r_count);
    end
  end

  assign count   = r_count;
  assign changed = r_changed;
  assign at_max  = (r_count == MAX_V);
  assign at_min  = (r_count == MIN_V);

endmodule

// File: tb/tb_length_adjust_counter.sv
// Directed bench for length_adjust_counter: a main instance (MAX 127) plus
// saturating and wrapping instances with MAX 5. All use a hold of 8 and a repeat of 4.
module tb_length_adjust_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, up, dn, sy, up3, dn3, sy3;
  logic [6:0] count, s_count, w_count;
  logic at_max, at_min, changed;
  logic s_at_max, s_at_min, s_changed;
  logic w_at_max, w_at_min, w_changed;

  length_adjust_counter #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst), .btn_up(up), .btn_down(dn), .sync(sy),
    .count(count), .at_max(at_max), .at_min(at_min), .changed(changed));

  length_adjust_counter #(.MAX_VAL(5), .WRAP(0), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut_sat (
    .clk(clk), .nrst(nrst), .btn_up(up3), .btn_down(dn3), .sync(sy3),
    .count(s_count), .at_max(s_at_max), .at_min(s_at_min), .changed(s_changed));

  length_adjust_counter #(.MAX_VAL(5), .WRAP(1), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut_wrap (
    .clk(clk), .nrst(nrst), .btn_up(up3), .btn_down(dn3), .sync(sy3),
    .count(w_count), .at_max(w_at_max), .at_min(w_at_min), .changed(w_changed));

  int n_cmp = 0;
  int n_mis = 0;
  int chg_main = 0;
  int chg_sat = 0;

  // Pulse counters on the change outputs
  always @(posedge clk) begin
    if (changed)   chg_main <= chg_main + 1;
    if (s_changed) chg_sat  <= chg_sat + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // which: 0 main up, 1 main down, 2 bounded up, 3 bounded down
  task automatic press(input int which, input int n);
    case (which)
      0: up = 1'b1;
      1: dn = 1'b1;
      2: up3 = 1'b1;
      default: dn3 = 1'b1;
    endcase
    repeat (n) @(negedge clk);
    up = 1'b0; dn = 1'b0; up3 = 1'b0; dn3 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  logic [6:0] log_c [1:40];
  int base;

  initial begin
    nrst = 1'b0; up = 1'b0; dn = 1'b0; sy = 1'b0; up3 = 1'b0; dn3 = 1'b0; sy3 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_changed", 32'(changed), 32'd0);
    check("rst_at_min", 32'(at_min), 32'd1);
    check("rst_at_max", 32'(at_max), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // 1: three short presses
    base = chg_main;
    for (int i = 1; i <= 3; i++) begin
      press(0, 3);
      check("t1_count", 32'(count), 32'(i));
      if (i == 1) check("t1_at_min", 32'(at_min), 32'd0);
    end
    check("t1_pulses", 32'(chg_main - base), 32'd3);

    // 2: hold up for 40 clocks
    do_reset();
    up = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      log_c[i] = count;
    end
    up = 1'b0;
    repeat (6) @(negedge clk);
    check("t2_before_first", 32'(log_c[2]), 32'd0);
    check("t2_first_step", 32'(log_c[3]), 32'd1);
    check("t2_hold_wait", 32'(log_c[10]), 32'd1);
    check("t2_first_repeat", 32'(log_c[11]), 32'd2);
    check("t2_rep_wait", 32'(log_c[14]), 32'd2);
    check("t2_second_repeat", 32'(log_c[15]), 32'd3);
    check("t2_third_repeat", 32'(log_c[19]), 32'd4);
    check("t2_pre_last", 32'(log_c[38]), 32'd8);
    check("t2_last", 32'(log_c[39]), 32'd9);
    check("t2_after_release", 32'(count), 32'd9);

    // 3: bounded instances, saturate vs wrap
    do_reset();
    base = chg_sat;
    for (int i = 1; i <= 8; i++) begin
      press(2, 3);
      check("t3_sat_count", 32'(s_count), 32'((i < 5) ? i : 5));
      check("t3_wrap_count", 32'(w_count), 32'(i % 6));
      if (i == 5) base = chg_sat;
    end
    check("t3_sat_no_pulse", 32'(chg_sat - base), 32'd0);
    check("t3_sat_at_max", 32'(s_at_max), 32'd1);
    press(3, 3);
    press(3, 3);
    check("t3_wrap_down0", 32'(w_count), 32'd0);
    check("t3_wrap_at_min", 32'(w_at_min), 32'd1);
    press(3, 3);
    check("t3_wrap_down_wrap", 32'(w_count), 32'd5);
    check("t3_wrap_at_max", 32'(w_at_max), 32'd1);
    check("t3_sat_down", 32'(s_count), 32'd2);

    // 4: sync collides with a step, then sync at MIN
    do_reset();
    for (int i = 0; i < 4; i++) press(0, 3);
    check("t4_count4", 32'(count), 32'd4);
    up = 1'b1;
    repeat (2) @(negedge clk);
    sy = 1'b1;
    @(negedge clk);
    sy = 1'b0;
    check("t4_sync_count", 32'(count), 32'd0);
    check("t4_sync_changed", 32'(changed), 32'd1);
    up = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_settled", 32'(count), 32'd0);
    sy = 1'b1;
    @(negedge clk);
    sy = 1'b0;
    check("t4_sync0_changed", 32'(changed), 32'd0);
    check("t4_sync0_count", 32'(count), 32'd0);

    // 5: second button during repeat
    do_reset();
    up = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_in_repeat", 32'(count), 32'd2);
    dn = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_both_held", 32'(count), 32'd2);
    dn = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_up_only_no_rise", 32'(count), 32'd2);
    up = 1'b0;
    repeat (6) @(negedge clk);
    press(0, 3);
    check("t5_repress", 32'(count), 32'd3);

    // 6: reset mid-repeat with up held through release
    do_reset();
    up = 1'b1;
    repeat (83) @(negedge clk);
    check("t6_count20", 32'(count), 32'd20);
    check("t6_changed_pre", 32'(changed), 32'd1);
    nrst = 1'b0;
    #1;
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_changed", 32'(changed), 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_no_step_yet", 32'(count), 32'd0);
    @(negedge clk);
    check("t6_step_after_rst", 32'(count), 32'd1);
    repeat (7) @(negedge clk);
    check("t6_hold_wait", 32'(count), 32'd1);
    @(negedge clk);
    check("t6_first_repeat", 32'(count), 32'd2);
    up = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
